fwd_conv_1025_1024_1023: RTL

FWD_CONV_1025_1024_1023 -- requirements
Module: fwd_conv_1025_1024_1023

---
 rtl/fwd_conv_1025_1024_1023.sv | 124 ++++++++++++
 1 files changed

// File: rtl/fwd_conv_1025_1024_1023.sv
// Forward residue converter: X -> (X mod 1025, X mod 1024, X mod 1023) in a
// two-stage valid/ready pipeline, with an optional X >= 1025*1024*1023 flag.
module fwd_conv_1025_1024_1023 #(
    parameter bit RANGE_CHECK = 1'b1
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [29:0] x_in,
    input  logic        in_valid_in,
    output logic        in_ready_out,
    output logic [10:0] r1_out,
    output logic [9:0]  r2_out,
    output logic [9:0]  r3_out,
    output logic        range_err_out,
    output logic        out_valid_out,
    input  logic        out_ready_in
);

    localparam logic [29:0] DYN_RANGE = 30'd1073740800;

    logic        s1_valid;
    logic [9:0]  s1_c;
    logic [11:0] s1_sum3;
    logic [11:0] s1_sum1;
    logic        s1_err;

    logic        s2_valid;
    logic [10:0] s2_r1;
    logic [9:0]  s2_r2;
    logic [9:0]  s2_r3;
    logic        s2_err;

    logic        s2_adv;
    logic        s1_adv;

    logic [9:0]  a_dig;
    logic [9:0]  b_dig;
    logic [9:0]  c_dig;
    logic [11:0] sum3_next;
    logic [11:0] sum1_next;
    logic        err_next;

    logic [10:0] fold_t;
    logic [9:0]  fold_u;
    logic [9:0]  r3_next;
    logic [11:0] r1_wide;
    logic [10:0] r1_next;

    assign s2_adv       = !s2_valid || out_ready_in;
    assign s1_adv       = !s1_valid || s2_adv;
    assign in_ready_out = s1_adv;

    // 2^10 = -1 (mod 1025) and 2^10 = 1 (mod 1023), so the three 10-bit
    // digits fold into one signed and one unsigned digit sum.
    always_comb begin
        a_dig     = x_in[29:20];
        b_dig     = x_in[19:10];
        c_dig     = x_in[9:0];
        sum3_next = {2'b00, a_dig} + {2'b00, b_dig} + {2'b00, c_dig};
        sum1_next = {2'b00, a_dig} + {2'b00, c_dig} + 12'd1025 - {2'b00, b_dig};
        err_next  = RANGE_CHECK ? (x_in >= DYN_RANGE) : 1'b0;
    end

    // End-around-carry folding for 1023; the all-ones pattern aliases zero.
    always_comb begin
        fold_t  = {1'b0, s1_sum3[9:0]} + {9'b0, s1_sum3[11:10]};
        fold_u  = fold_t[9:0] + {9'b0, fold_t[10]};
        r3_next = (fold_u == 10'd1023) ? 10'd0 : fold_u;
    end

    always_comb begin
        if (s1_sum1 >= 12'd2050) begin
            r1_wide = s1_sum1 - 12'd2050;
        end else if (s1_sum1 >= 12'd1025) begin
            r1_wide = s1_sum1 - 12'd1025;
        end else begin
            r1_wide = s1_sum1;
        end
        r1_next = r1_wide[10:0];
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            s1_valid <= 1'b0;
            s1_c     <= '0;
            s1_sum3  <= '0;
            s1_sum1  <= '0;
            s1_err   <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid_in;
            if (in_valid_in) begin
                s1_c    <= c_dig;
                s1_sum3 <= sum3_next;
                s1_sum1 <= sum1_next;
                s1_err  <= err_next;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            s2_valid <= 1'b0;
            s2_r1    <= '0;
            s2_r2    <= '0;
            s2_r3    <= '0;
            s2_err   <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_r1  <= r1_next;
                s2_r2  <= s1_c;
                s2_r3  <= r3_next;
                s2_err <= s1_err;
            end
        end
    end

    assign out_valid_out = s2_valid;
    assign r1_out        = s2_r1;
    assign r2_out        = s2_r2;
    assign r3_out        = s2_r3;
    assign range_err_out = s2_err;

endmodule
